// File: rtl/press_pulse_generator.sv
// Turns single-cycle press requests into fixed-length high/low press waveforms
// on D_out, queueing requests that arrive while a press is being generated.
module press_pulse_generator #(
    parameter int HIGH_CYCLES = 16,
    parameter int GAP_CYCLES  = 16,
    parameter int CNT_W       = 8,
    parameter int PEND_W      = 4
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              pulse_in,
    input  logic              clear,
    output logic              D_out,
    output logic              busy,
    output logic              done,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    // pulse_in has no back-pressure: every cycle it is sampled high is one request,
    // either started, queued in pending, or dropped (flagged by overflow).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              cnt_zero;
    logic              consume;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        ovf_d    = ovf_q;
        consume  = 1'b0;
        cnt_zero = (cnt_q == '0);

        case (state_q)
            IDLE: begin
                if (pulse_in) begin
                    state_d = HIGH;
                    cnt_d   = HIGH_LOAD;
                end
            end
            HIGH: begin
                if (cnt_zero) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    // Back-to-back replay: the next press starts straight after the gap.
                    if ((pend_q != '0) || pulse_in) begin
                        consume = 1'b1;
                        state_d = HIGH;
                        cnt_d   = HIGH_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A live request at a consuming edge replaces the queued one it would have used.
        if (consume) begin
            if ((pend_q != '0) && !pulse_in) begin
                pend_d = pend_q - PEND_W'(1);
            end
        end else if (pulse_in && (state_q != IDLE)) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end

        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            pend_d  = '0;
            ovf_d   = 1'b0;
        end
    end

    assign D_out    = (state_q == HIGH);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == GAP) && cnt_zero;
    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_press_pulse_generator.sv
// Directed bench for press_pulse_generator: press timing, queueing, saturation,
// back-to-back replay, clear and asynchronous reset.
module tb_press_pulse_generator;

    logic       clk_in;
    logic       reset;
    logic       pulse_in;
    logic       clear;
    logic       D_out;
    logic       busy;
    logic       done;
    logic [3:0] pending;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;
    int rises;
    int dones;
    int e_pend;
    logic prev_d;

    press_pulse_generator dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .pulse_in (pulse_in),
        .clear    (clear),
        .D_out    (D_out),
        .busy     (busy),
        .done     (done),
        .pending  (pending),
        .overflow (overflow)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Advance one edge; sample and drive 1 time unit after it.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, c, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int c, input logic d, input logic b,
                              input logic dn, input logic [3:0] p, input logic ov);
        chk({tag, ".D_out"}, c, 32'(D_out), 32'(d));
        chk({tag, ".busy"}, c, 32'(busy), 32'(b));
        chk({tag, ".done"}, c, 32'(done), 32'(dn));
        chk({tag, ".pending"}, c, 32'(pending), 32'(p));
        chk({tag, ".overflow"}, c, 32'(overflow), 32'(ov));
    endtask

    // One isolated press from IDLE: high cycles 1..16, low 17..32, done at 32.
    task automatic single_press(input string tag);
        pulse_in = 1'b1;
        tick();
        pulse_in = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            expect_out(tag, c, (c <= 16), (c <= 32), (c == 32), 4'd0, 1'b0);
            tick();
        end
    endtask

    // Press at edge 0, pulse_in held over edges 1..20; returns in cycle last_c unticked.
    task automatic run_sat(input string tag, input int last_c, output int n_rise);
        int   ep;
        logic pd;
        n_rise = 0;
        pd = 1'b0;
        pulse_in = 1'b1;
        tick();
        for (int c = 1; c <= last_c; c++) begin
            if (c <= 16) ep = c - 1;
            else ep = 15 - (c - 1) / 32;
            if (ep < 0) ep = 0;
            expect_out(tag, c, (c <= 512) && (((c - 1) % 32) < 16), (c <= 512),
                       (c <= 512) && ((c % 32) == 0), 4'(ep), (c >= 17));
            if (D_out && !pd) n_rise++;
            pd = D_out;
            pulse_in = (c <= 20);
            if (c < last_c) tick();
        end
        pulse_in = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        pulse_in = 1'b0;
        clear    = 1'b0;
        #12;
        expect_out("reset", 0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        expect_out("idle", 0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Single press timing.
        single_press("single");

        // Two queued requests replayed back-to-back.
        rises = 0;
        dones = 0;
        prev_d = 1'b0;
        pulse_in = 1'b1;
        tick();
        for (int c = 1; c <= 100; c++) begin
            if (c <= 5) e_pend = 0;
            else if (c <= 20) e_pend = 1;
            else if (c <= 32) e_pend = 2;
            else if (c <= 64) e_pend = 1;
            else e_pend = 0;
            expect_out("queue", c, (c <= 80) && (((c - 1) % 32) < 16), (c <= 96),
                       (c == 32) || (c == 64) || (c == 96), 4'(e_pend), 1'b0);
            if (D_out && !prev_d) rises++;
            if (done) dones++;
            prev_d = D_out;
            pulse_in = (c == 5) || (c == 20);
            tick();
        end
        chk("queue.presses", 100, 32'(rises), 32'd3);
        chk("queue.dones", 100, 32'(dones), 32'd3);

        // Saturation: 15 queued + 1 live = 16 presses, overflow sticky.
        run_sat("sat", 515, rises);
        chk("sat.presses", 515, 32'(rises), 32'd16);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        expect_out("sat.clear", 516, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Live request in the final gap cycle starts the next press with no idle cycle.
        pulse_in = 1'b1;
        tick();
        for (int c = 1; c <= 66; c++) begin
            expect_out("b2b", c, (c <= 64) && (((c - 1) % 32) < 16), (c <= 64),
                       (c == 32) || (c == 64), 4'd0, 1'b0);
            pulse_in = (c == 32);
            tick();
        end

        // Clear in cycle 8 of a press with pending=3 and overflow=1; coincident pulse dropped.
        run_sat("pre_clear", 392, rises);
        expect_out("pre_clear.state", 392, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1);
        clear = 1'b1;
        pulse_in = 1'b1;
        tick();
        clear = 1'b0;
        pulse_in = 1'b0;
        for (int c = 393; c <= 400; c++) begin
            expect_out("clear", c, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
            tick();
        end

        // Asynchronous reset in the middle of the gap.
        pulse_in = 1'b1;
        tick();
        pulse_in = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        expect_out("pre_reset", 20, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        expect_out("async_reset", 20, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        tick();
        #2;
        reset = 1'b0;
        tick();
        expect_out("post_reset", 0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        single_press("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
